// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin / fixed-select stream mux.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-id width; never below one bit so a 1-channel field stays legal.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping modulo NUM_CH.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with fixed-select or round-robin arbitration and one registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic [NUM_CH-1:0] rr_grant;
    logic [NUM_CH-1:0] fix_grant;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  rr_ptr;
    logic              can_load;
    logic              accept;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (mode == MODE_RR),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // An out-of-range sel grants nothing; the range test guards the index.
    always_comb begin
        fix_grant = '0;
        if ((int'(sel) < NUM_CH) && in_valid[sel])
            fix_grant[sel] = 1'b1;
    end

    assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
    assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
    assign can_load  = ~out_valid | out_ready;
    assign accept    = (|grant) & can_load;
    assign in_ready  = grant & {NUM_CH{can_load}};

    // NOTE: state registers use non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else if (accept) begin
            out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            rr_ptr    <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the 4:1 registered data mux in the decoder/control path.
- Generalises width and channel count, and adds per-channel valid/ready handshakes.
- Two modes: fixed-select (software steers a channel) or round-robin arbitration.
- Output is a single registered pipeline stage with full throughput under backpressure; feeds instruction/operand registers downstream.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_CH, 4, number of input channels (>=2; need not be a power of two).
- SEL_W, $clog2(NUM_CH), width of select/channel-id fields (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  selected channel in fixed mode; ignored in round-robin.
- in_data  in  NUM_CH*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready (combinational).
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ch  out  SEL_W  registered index of the channel that supplied out_data.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at clock edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, so channel 0 has top priority after reset. A held word is discarded; reset mid-transfer takes priority over everything.
- can_load = ~out_valid | out_ready (combinational).
- Grant is combinational and one-hot or zero:
  - Fixed mode: grant[sel]=1 iff in_valid[sel] and sel<NUM_CH. sel>=NUM_CH grants nothing; no load occurs and no X may propagate.
  - Round-robin mode: grant the first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH with wrap-around.
- in_ready[i] = grant[i] & can_load. Non-granted channels see in_ready=0.
- Transfer (accept) when any grant & can_load. Next edge: out_data <= granted channel data, out_ch <= granted index, out_valid <= 1, rr_ptr <= granted index.
- rr_ptr updates on every accept in both modes. A mode switch takes effect at the next arbitration and does not reset rr_ptr.
- If out_valid & out_ready and there is no accept, out_valid <= 0; out_data and out_ch hold their last values.
- If out_valid & ~out_ready: out_data, out_ch and out_valid hold stable; in_ready = 0 on all channels.
- Simultaneous drain and accept (out_valid & out_ready & accept): the new word replaces the old one in the same edge; out_valid stays 1. Sustained throughput is 1 word/cycle.
- Latency: accepted word appears on out_* exactly 1 cycle after the accept edge.
- A single requester in round-robin is granted every cycle (no bubbles).
- No data modification; widths pass through unchanged.

Decomposition:
- Shared package holds:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - a width-helper function for SEL_W if the codebase package already carries clog2 helpers.
- One sub-module, rr_arbiter (params NUM_CH; inputs req, ptr, en; output one-hot grant, grant_idx).
- Top level handles mode muxing, the ready logic and the output register.

Test Plan:
- Fixed mode, all valid, in0..in3=0xAA,0x55,0x23,0x78, out_ready=1, sel stepped 0..3 → out_data = AA,55,23,78 one cycle after each sel; out_ch = sel.
- Round-robin, all four valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,… with matching data; out_valid stays 1 with no bubbles.
- Backpressure: fill output, hold out_ready=0 for 3 cycles → out_data/out_ch stable, in_ready=0000. Release → next channel in round-robin order loaded the same edge.
- Sparse requests in round-robin: only ch1 and ch3 valid → alternates 1,3,1,3. Drop ch3 → ch1 every cycle.
- Fixed mode, NUM_CH=3 instance, sel=3 → in_ready=000 and out_valid falls after drain. sel=0xB? N/A; then sel=2 with in2=0x23 → out_data=0x23.
- Assert rst for one cycle while out_valid=1 and out_ready=0 → out_valid=0, out_data=0, out_ch=0. Next round-robin grant goes to ch0 when all are valid.
